oram_block_adapter: RTL and testbench

//  Upstream stage feeding TinyORAMCore's frontend port. Accepts one full ORAMB-bit block request (cmd, addr, data),

---
 rtl/oram_block_adapter_if.sv | 41 ++++
 rtl/oram_block_adapter.sv | 124 ++++++++++++
 tb/tb_oram_block_adapter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/oram_block_adapter_if.sv
// rtl/oram_block_adapter_if.sv - request/response and ORAM frontend signal bundle for oram_block_adapter
interface oram_block_adapter_if #(
    parameter int ORAMB    = 512,
    parameter int ORAMU    = 32,
    parameter int FEDWidth = 64
);
    logic [1:0]          ReqCmd;
    logic [ORAMU-1:0]    ReqAddr;
    logic [ORAMB-1:0]    ReqData;
    logic                ReqValid;
    logic                ReqReady;
    logic [ORAMB-1:0]    RespData;
    logic [ORAMU-1:0]    RespAddr;
    logic                RespValid;
    logic                RespReady;
    logic [1:0]          Cmd;
    logic [ORAMU-1:0]    PAddr;
    logic                CmdValid;
    logic                CmdReady;
    logic [FEDWidth-1:0] DataIn;
    logic                DataInValid;
    logic                DataInReady;
    logic [FEDWidth-1:0] DataOut;
    logic                DataOutValid;
    logic                DataOutReady;

    // slave: the adapter itself; master: the surrounding requester plus ORAM
    modport slave (
        input  ReqCmd, ReqAddr, ReqData, ReqValid, RespReady,
        input  CmdReady, DataInReady, DataOut, DataOutValid,
        output ReqReady, RespData, RespAddr, RespValid,
        output Cmd, PAddr, CmdValid, DataIn, DataInValid, DataOutReady
    );

    modport master (
        output ReqCmd, ReqAddr, ReqData, ReqValid, RespReady,
        output CmdReady, DataInReady, DataOut, DataOutValid,
        input  ReqReady, RespData, RespAddr, RespValid,
        input  Cmd, PAddr, CmdValid, DataIn, DataInValid, DataOutReady
    );
endinterface

// File: rtl/oram_block_adapter.sv
// rtl/oram_block_adapter.sv - block request to ORAM frontend adapter (serialize writes, assemble reads)
module oram_block_adapter #(
    parameter int ORAMB    = 512,
    parameter int ORAMU    = 32,
    parameter int FEDWidth = 64
) (
    input  logic                  Clock,
    input  logic                  Reset,
    oram_block_adapter_if.slave   bus
);
    localparam int Chunks = ORAMB / FEDWidth;
    localparam int CW     = $clog2(Chunks);
    localparam logic [CW-1:0] LastBeat = CW'(Chunks - 1);

    typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, RESP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        cmd_q, cmd_d;
    logic [ORAMU-1:0]  addr_q, addr_d;
    logic [ORAMB-1:0]  blk_q, blk_d;
    logic              req_ready_q, req_ready_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              data_in_valid_q, data_in_valid_d;
    logic              data_out_ready_q, data_out_ready_d;
    logic              resp_valid_q, resp_valid_d;

    // blk_q holds the write block (shifted out MS first) or the read block (shifted in LS side)
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        blk_d   = blk_q;
        case (state_q)
            IDLE: begin
                if (bus.ReqValid && req_ready_q) begin
                    cmd_d   = bus.ReqCmd;
                    addr_d  = bus.ReqAddr;
                    blk_d   = bus.ReqData;
                    state_d = CMD;
                end
            end
            CMD: begin
                if (bus.CmdReady && cmd_valid_q) begin
                    cnt_d   = '0;
                    state_d = cmd_q[1] ? RDATA : WDATA;
                end
            end
            WDATA: begin
                if (bus.DataInReady && data_in_valid_q) begin
                    blk_d = {blk_q[ORAMB-FEDWidth-1:0], {FEDWidth{1'b0}}};
                    if (cnt_q == LastBeat) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            RDATA: begin
                if (bus.DataOutValid && data_out_ready_q) begin
                    blk_d = {blk_q[ORAMB-FEDWidth-1:0], bus.DataOut};
                    if (cnt_q == LastBeat) begin
                        cnt_d   = '0;
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            RESP: begin
                if (bus.RespReady && resp_valid_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // handshake outputs are registered images of the next state
        req_ready_d      = (state_d == IDLE);
        cmd_valid_d      = (state_d == CMD);
        data_in_valid_d  = (state_d == WDATA);
        data_out_ready_d = (state_d == RDATA);
        resp_valid_d     = (state_d == RESP);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            cmd_q            <= '0;
            addr_q           <= '0;
            blk_q            <= '0;
            req_ready_q      <= 1'b0;
            cmd_valid_q      <= 1'b0;
            data_in_valid_q  <= 1'b0;
            data_out_ready_q <= 1'b0;
            resp_valid_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            cmd_q            <= cmd_d;
            addr_q           <= addr_d;
            blk_q            <= blk_d;
            req_ready_q      <= req_ready_d;
            cmd_valid_q      <= cmd_valid_d;
            data_in_valid_q  <= data_in_valid_d;
            data_out_ready_q <= data_out_ready_d;
            resp_valid_q     <= resp_valid_d;
        end
    end

    assign bus.ReqReady     = req_ready_q;
    assign bus.Cmd          = cmd_q;
    assign bus.PAddr        = addr_q;
    assign bus.CmdValid     = cmd_valid_q;
    assign bus.DataIn       = blk_q[ORAMB-1 -: FEDWidth];
    assign bus.DataInValid  = data_in_valid_q;
    assign bus.DataOutReady = data_out_ready_q;
    assign bus.RespData     = blk_q;
    assign bus.RespAddr     = addr_q;
    assign bus.RespValid    = resp_valid_q;
endmodule

// File: tb/tb_oram_block_adapter.sv
// tb/tb_oram_block_adapter.sv - scoreboard testbench for oram_block_adapter
module tb_oram_block_adapter;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    oram_block_adapter_if bus ();

    oram_block_adapter dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [511:0] data;
        logic [31:0]  addr;
    } resp_t;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int beat_cnt = 0;
    int last_beat_cyc = 0;
    logic rd_hs;

    logic [33:0] exp_cmd[$];
    logic [63:0] exp_beat[$];
    resp_t       exp_resp[$];
    logic [63:0] rd_beats[$];

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_event(input string nm);
        n_vec++;
        n_fail++;
        $display("FAIL %s: event not expected or not seen in time", nm);
    endtask

    function automatic logic [511:0] mk(input logic [63:0] base);
        logic [511:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r[511-64*k -: 64] = base + 64'(k);
        return r;
    endfunction

    // monitor: pops the scoreboard whenever the DUT completes a handshake
    always @(negedge Clock) begin
        if (Reset) begin
            if (bus.CmdValid && bus.CmdReady) begin
                if (exp_cmd.size() == 0) fail_event("cmd_unexpected");
                else check("cmd", {bus.Cmd, bus.PAddr}, exp_cmd.pop_front());
            end
            if (bus.DataInValid && bus.DataInReady) begin
                beat_cnt++;
                last_beat_cyc = cyc;
                if (exp_beat.size() == 0) fail_event("beat_unexpected");
                else check("data_in_beat", bus.DataIn, exp_beat.pop_front());
            end
            if (bus.RespValid && bus.RespReady) begin
                if (exp_resp.size() == 0) fail_event("resp_unexpected");
                else begin
                    resp_t e;
                    e = exp_resp.pop_front();
                    check("resp_data", bus.RespData, e.data);
                    check("resp_addr", bus.RespAddr, e.addr);
                end
            end
        end
    end

    // ORAM read side: presents queued beats, pops on handshake
    initial begin
        bus.DataOutValid = 1'b0;
        bus.DataOut      = '0;
        forever begin
            @(negedge Clock);
            rd_hs = bus.DataOutValid && bus.DataOutReady;
            @(posedge Clock);
            #1;
            if (rd_hs && rd_beats.size() > 0) void'(rd_beats.pop_front());
            bus.DataOutValid = (rd_beats.size() > 0);
            bus.DataOut      = (rd_beats.size() > 0) ? rd_beats[0] : 64'd0;
        end
    end

    task automatic send_req(input logic [1:0] c, input logic [31:0] a, input logic [63:0] base);
        resp_t r;
        bit ok;
        ok = 1'b0;
        exp_cmd.push_back({c, a});
        if (c < 2'd2) begin
            for (int k = 0; k < 8; k++) exp_beat.push_back(base + 64'(k));
        end else begin
            r.data = mk(base);
            r.addr = a;
            exp_resp.push_back(r);
            for (int k = 0; k < 8; k++) rd_beats.push_back(base + 64'(k));
        end
        @(posedge Clock);
        #1;
        bus.ReqCmd   = c;
        bus.ReqAddr  = a;
        bus.ReqData  = (c < 2'd2) ? mk(base) : 512'd0;
        bus.ReqValid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge Clock);
            if (bus.ReqReady) ok = 1'b1;
        end
        if (!ok) fail_event("req_accept_timeout");
        @(posedge Clock);
        #1;
        bus.ReqValid = 1'b0;
    endtask

    task automatic wait_idle(input string nm, output int ic);
        bit ok;
        ok = 1'b0;
        ic = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge Clock);
            #1;
            if (bus.ReqReady && exp_cmd.size() == 0 && exp_beat.size() == 0 && exp_resp.size() == 0) begin
                ok = 1'b1;
                ic = cyc;
            end
        end
        if (!ok) fail_event(nm);
    endtask

    initial begin
        int ic;
        bit ok;
        bus.ReqCmd      = '0;
        bus.ReqAddr     = '0;
        bus.ReqData     = '0;
        bus.ReqValid    = 1'b0;
        bus.RespReady   = 1'b1;
        bus.CmdReady    = 1'b1;
        bus.DataInReady = 1'b1;
        #1 Reset = 1'b0;

        // reset hold and release
        repeat (10) begin
            @(negedge Clock);
            check("reset_handshakes", {bus.ReqReady, bus.CmdValid, bus.DataInValid,
                                       bus.DataOutReady, bus.RespValid}, 5'b0);
        end
        check("reset_resp_data", bus.RespData, 512'd0);
        @(posedge Clock);
        #2 Reset = 1'b1;
        @(posedge Clock);
        #1 check("req_ready_first_posedge", bus.ReqReady, 1'b1);

        // append with all-ready ORAM
        beat_cnt = 0;
        send_req(2'd1, 32'd5, 64'd5);
        wait_idle("append_idle_timeout", ic);
        check("append_beat_count", beat_cnt, 8);
        check("req_ready_after_last_beat", ic, last_beat_cyc + 1);

        // read back
        send_req(2'd2, 32'd5, 64'd5);
        wait_idle("read_idle_timeout", ic);

        // command backpressure then alternating data backpressure
        bus.CmdReady = 1'b0;
        beat_cnt = 0;
        send_req(2'd0, 32'h1234, 64'h100);
        repeat (10) begin
            @(negedge Clock);
            check("cmd_held", {bus.CmdValid, bus.Cmd, bus.PAddr}, {1'b1, 2'd0, 32'h1234});
        end
        @(posedge Clock);
        #1 bus.CmdReady = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge Clock);
            #1;
            if (bus.ReqReady) ok = 1'b1;
            @(posedge Clock);
            #1 bus.DataInReady = ~bus.DataInReady;
        end
        if (!ok) fail_event("toggle_write_timeout");
        bus.DataInReady = 1'b1;
        check("toggle_beat_count", beat_cnt, 8);
        check("toggle_beats_drained", exp_beat.size(), 0);

        // response backpressure with a stray read beat
        bus.RespReady = 1'b0;
        send_req(2'd3, 32'h77, 64'h40);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge Clock);
            if (bus.RespValid) ok = 1'b1;
        end
        if (!ok) fail_event("resp_valid_timeout");
        rd_beats.push_back(64'hDEAD);
        repeat (5) begin
            @(negedge Clock);
            check("resp_hold_handshakes", {bus.RespValid, bus.ReqReady, bus.DataOutReady}, 3'b100);
            check("resp_hold_data", bus.RespData, mk(64'h40));
            check("resp_hold_addr", bus.RespAddr, 32'h77);
        end
        rd_beats.delete();
        @(posedge Clock);
        #1 bus.RespReady = 1'b1;
        wait_idle("readrmv_idle_timeout", ic);

        // reset in the middle of an update
        beat_cnt = 0;
        send_req(2'd0, 32'd7, 64'h200);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge Clock);
            #1;
            if (beat_cnt == 3) ok = 1'b1;
        end
        if (!ok) fail_event("three_beats_timeout");
        @(posedge Clock);
        #1 Reset = 1'b0;
        #1 check("async_reset_drop", {bus.ReqReady, bus.CmdValid, bus.DataInValid,
                                      bus.DataOutReady, bus.RespValid}, 5'b0);
        exp_beat.delete();
        repeat (3) @(posedge Clock);
        #2 Reset = 1'b1;
        beat_cnt = 0;
        send_req(2'd0, 32'd9, 64'h300);
        wait_idle("update_after_reset_timeout", ic);
        check("post_reset_beat_count", beat_cnt, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
